i2c_reg_file: RTL and testbench
===============================

I2C_REG_FILE -- requirements
Module: i2c_reg_file

Interface
REQ-001 The block SHALL have parameter DEV_ID, default 8'hA5, the value returned by a read of address 0x0F.
REQ-002 The block SHALL have parameter CFG0_RST, default 8'h01, the reset value of cfg register 0.
REQ-003 Port clk, input, 1: single system clock; all state updates on rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port i2c_xfc_write, input, 1: one-cycle write request from the I2C slave.
REQ-006 Port i2c_xfc_read, input, 1: one-cycle read request from the I2C slave.
REQ-007 Port i2c_addr, input, 8: register address, sampled with the request.
REQ-008 Port i2c_wdata, input, 8: write data, sampled with the request.
REQ-009 Port i2c_rdata, output, 8: read data, valid while i2c_ack=1.
REQ-010 Port i2c_ack, output, 1: one-cycle transfer-complete pulse.
REQ-011 Port i2c_err, output, 1: qualifies i2c_ack; 1 = transfer rejected.
REQ-012 Port cfg_regs, output, 64: registers 0x00-0x07 flattened; reg n in bits [8n+7:8n].
REQ-013 Port cfg_wr_pulse, output, 8: bit n high for one cycle when reg n is written.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, EXEC and ACK.
- IDLE->EXEC: request sampled.
- EXEC->ACK: unconditionally.
- ACK->IDLE: unconditionally.
REQ-015 In IDLE, a request on cycle N SHALL latch addr, wdata and type, then enter EXEC on N+1; i2c_ack SHALL be 1 on cycle N+2 only.
REQ-016 In EXEC, a write to 0x00-0x07 SHALL update that reg and pulse its cfg_wr_pulse bit; cfg_regs SHALL show the new value from N+2.
REQ-017 In EXEC, a read SHALL load i2c_rdata as follows, held from N+2 until the next ACK:
- 0x00-0x07: reg value.
- 0x0E: status.
- 0x0F: DEV_ID.
- any other address: 0x00.
REQ-018 The status register (0x0E) SHALL have this layout:
- bit0 busy_err: sticky.
- bit1 addr_err: sticky.
- bit2: 0.
- bit3 both_err: sticky.
- bits7:4 wr_cnt.
REQ-019 A write to 0x0E SHALL clear the sticky bits written as 1 (W1C) and SHALL NOT alter wr_cnt.
REQ-020 wr_cnt SHALL increment by 1 on each successful write to 0x00-0x07 and SHALL wrap from 15 to 0.
REQ-021 Address rejection SHALL behave as follows:
- Write to 0x0F, or any access to 0x08-0x0D or 0x10-0xFF: no register change, addr_err set.
- Response: i2c_ack with i2c_err=1.
REQ-022 Simultaneous i2c_xfc_write and i2c_xfc_read in IDLE SHALL set both_err, perform no access, and still produce i2c_ack with i2c_err=1 on N+2.
REQ-023 Requests arriving in EXEC or ACK SHALL be dropped and SHALL set busy_err; the in-flight transfer SHALL complete normally.
REQ-024 i2c_err SHALL be 0 whenever i2c_ack is 0.

Reset
REQ-025 While reset=1 on a rising edge, the block SHALL set:
- FSM to IDLE.
- cfg reg 0 to CFG0_RST; regs 1-7 to 0x00.
- status to 0x00.
- i2c_rdata, i2c_ack, i2c_err, cfg_wr_pulse to 0.
REQ-026 A reset asserted during EXEC or ACK SHALL abort the transfer, suppress i2c_ack, and leave no partial register write.
REQ-027 Requests coincident with reset SHALL be ignored.

Verification
REQ-028 Reset check: reset released -> cfg_regs = 64'h0000_0000_0000_0001 and a read of 0x0F gives rdata=0xA5, ack on N+2, err=0.
REQ-029 Write/readback: write 0x03<-0x5C -> cfg_wr_pulse=8'b0000_1000 for one cycle; read 0x03 gives 0x5C; status wr_cnt=1.
REQ-030 Wrap: 16 writes to 0x00 -> wr_cnt=0; a 17th write -> wr_cnt=1.
REQ-031 Errors:
- Write 0x0F -> err=1 and status=0x02.
- Write/read pulse together -> err=1 and status bit3=1.
- Request at N+1 -> status bit0=1.
- Write 0x0E<-0x0B -> status low nibble=0.
REQ-032 Reset mid-op: write 0x05<-0xFF, reset on N+1 -> no ack and reg 5 = 0x00.

Source files
------------

// File: rtl/i2c_reg_file.sv
// Register file behind an I2C slave: eight config registers, a status register
// with sticky error flags and a write counter, and a read-only device ID.
module i2c_reg_file #(
  parameter logic [7:0] DEV_ID   = 8'hA5,
  parameter logic [7:0] CFG0_RST = 8'h01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i2c_xfc_write,
  input  logic        i2c_xfc_read,
  input  logic [7:0]  i2c_addr,
  input  logic [7:0]  i2c_wdata,
  output logic [7:0]  i2c_rdata,
  output logic        i2c_ack,
  output logic        i2c_err,
  output logic [63:0] cfg_regs,
  output logic [7:0]  cfg_wr_pulse
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  localparam logic [7:0] ADDR_STATUS = 8'h0E;
  localparam logic [7:0] ADDR_DEV_ID = 8'h0F;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [7:0]      r_addr;
  logic [7:0]      r_wdata;
  logic            r_is_wr;
  logic            r_both;
  logic [7:0][7:0] r_cfg;
  logic            r_busy_err;
  logic            r_addr_err;
  logic            r_both_err;
  logic [3:0]      r_wr_cnt;

  logic            w_req;
  logic            w_cfg_hit;
  logic            w_wr_ok;
  logic            w_rd_ok;
  logic            w_addr_bad;
  logic [7:0]      w_status;
  logic [7:0]      w_rd_mux;

  assign w_req      = i2c_xfc_write | i2c_xfc_read;
  assign w_cfg_hit  = (r_addr[7:3] == 5'd0);
  assign w_wr_ok    = r_is_wr & ~r_both & (w_cfg_hit | (r_addr == ADDR_STATUS));
  assign w_rd_ok    = ~r_is_wr & ~r_both &
                      (w_cfg_hit | (r_addr == ADDR_STATUS) | (r_addr == ADDR_DEV_ID));
  assign w_addr_bad = ~r_both & ~w_wr_ok & ~w_rd_ok;
  assign w_status   = {r_wr_cnt, r_both_err, 1'b0, r_addr_err, r_busy_err};
  assign cfg_regs   = r_cfg;

  // Read data source for an accepted read.
  always_comb begin
    w_rd_mux = 8'h00;
    if (w_cfg_hit)                  w_rd_mux = r_cfg[r_addr[2:0]];
    else if (r_addr == ADDR_STATUS) w_rd_mux = w_status;
    else if (r_addr == ADDR_DEV_ID) w_rd_mux = DEV_ID;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_req) w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_ACK;
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_addr       <= 8'h00;
      r_wdata      <= 8'h00;
      r_is_wr      <= 1'b0;
      r_both       <= 1'b0;
      r_cfg        <= {56'd0, CFG0_RST};
      r_busy_err   <= 1'b0;
      r_addr_err   <= 1'b0;
      r_both_err   <= 1'b0;
      r_wr_cnt     <= 4'd0;
      i2c_rdata    <= 8'h00;
      i2c_ack      <= 1'b0;
      i2c_err      <= 1'b0;
      cfg_wr_pulse <= 8'h00;
    end else begin
      r_state      <= w_state_nxt;
      i2c_ack      <= 1'b0;
      i2c_err      <= 1'b0;
      cfg_wr_pulse <= 8'h00;

      if (r_state == S_IDLE && w_req) begin
        r_addr  <= i2c_addr;
        r_wdata <= i2c_wdata;
        r_is_wr <= i2c_xfc_write;
        r_both  <= i2c_xfc_write & i2c_xfc_read;
        if (i2c_xfc_write && i2c_xfc_read) r_both_err <= 1'b1;
      end

      if (r_state == S_EXEC) begin
        i2c_ack <= 1'b1;
        i2c_err <= r_both | w_addr_bad;
        if (w_addr_bad) r_addr_err <= 1'b1;
        if (w_wr_ok && w_cfg_hit) begin
          r_cfg[r_addr[2:0]]        <= r_wdata;
          cfg_wr_pulse[r_addr[2:0]] <= 1'b1;
          r_wr_cnt                  <= r_wr_cnt + 4'd1;
        end
        if (w_wr_ok && r_addr == ADDR_STATUS) begin
          if (r_wdata[0]) r_busy_err <= 1'b0;
          if (r_wdata[1]) r_addr_err <= 1'b0;
          if (r_wdata[3]) r_both_err <= 1'b0;
        end
        if (w_rd_ok)                  i2c_rdata <= w_rd_mux;
        else if (!r_is_wr && !r_both) i2c_rdata <= 8'h00;
      end

      // Placed last so a dropped request wins over a same-cycle W1C clear.
      if (r_state != S_IDLE && w_req) r_busy_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_i2c_reg_file.sv
// Scoreboard bench for i2c_reg_file: stimulus pushes expected ack responses,
// a monitor pops them on every observed ack.
module tb_i2c_reg_file;

  logic        clk = 1'b0;
  logic        reset;
  logic        i2c_xfc_write;
  logic        i2c_xfc_read;
  logic [7:0]  i2c_addr;
  logic [7:0]  i2c_wdata;
  logic [7:0]  i2c_rdata;
  logic        i2c_ack;
  logic        i2c_err;
  logic [63:0] cfg_regs;
  logic [7:0]  cfg_wr_pulse;

  typedef struct {
    int         cyc;
    logic       err;
    logic       chk_rd;
    logic [7:0] rd;
    string      name;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] pulse_at_ack;
  logic [7:0] pulse_after;

  i2c_reg_file dut (
    .clk          (clk),
    .reset        (reset),
    .i2c_xfc_write(i2c_xfc_write),
    .i2c_xfc_read (i2c_xfc_read),
    .i2c_addr     (i2c_addr),
    .i2c_wdata    (i2c_wdata),
    .i2c_rdata    (i2c_rdata),
    .i2c_ack      (i2c_ack),
    .i2c_err      (i2c_err),
    .cfg_regs     (cfg_regs),
    .cfg_wr_pulse (cfg_wr_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: every ack must match the head of the scoreboard queue.
  initial begin
    forever begin
      @(negedge clk);
      if (!i2c_ack) check("err_without_ack", 64'(i2c_err), 64'd0);
      else if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check({e.name, "_ack_cycle"}, 64'(cyc), 64'(e.cyc));
        check({e.name, "_err"}, 64'(i2c_err), 64'(e.err));
        if (e.chk_rd) check({e.name, "_rdata"}, 64'(i2c_rdata), 64'(e.rd));
      end
    end
  end

  task automatic push(input string name, input logic err, input logic chk_rd, input logic [7:0] rd);
    exp_t e;
    e.cyc = cyc + 2; e.err = err; e.chk_rd = chk_rd; e.rd = rd; e.name = name;
    q.push_back(e);
  endtask

  task automatic idle_inputs();
    i2c_xfc_write = 1'b0; i2c_xfc_read = 1'b0; i2c_addr = 8'h00; i2c_wdata = 8'h00;
  endtask

  // One complete transfer; returns at the negedge after the FSM is back in IDLE.
  task automatic op(input string name, input logic wr, input logic rd, input logic [7:0] addr,
                    input logic [7:0] wdata, input logic exp_err, input logic chk_rd,
                    input logic [7:0] exp_rd);
    @(negedge clk);
    push(name, exp_err, chk_rd, exp_rd);
    i2c_xfc_write = wr; i2c_xfc_read = rd; i2c_addr = addr; i2c_wdata = wdata;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    pulse_at_ack = cfg_wr_pulse;
    @(negedge clk);
    pulse_after = cfg_wr_pulse;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    pulse_at_ack = 8'h00;
    pulse_after  = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset values and device ID
    check("rst_cfg_regs", cfg_regs, 64'h0000_0000_0000_0001);
    check("rst_outputs", {i2c_rdata, i2c_ack, i2c_err, cfg_wr_pulse}, '0);
    op("rd_devid", 1'b0, 1'b1, 8'h0F, 8'h00, 1'b0, 1'b1, 8'hA5);

    // Write / readback
    op("wr_r3", 1'b1, 1'b0, 8'h03, 8'h5C, 1'b0, 1'b0, 8'h00);
    check("wr_r3_pulse", 64'(pulse_at_ack), 64'h08);
    check("wr_r3_pulse_clr", 64'(pulse_after), 64'h00);
    check("wr_r3_cfg", cfg_regs, 64'h0000_0000_5C00_0001);
    op("rd_r3", 1'b0, 1'b1, 8'h03, 8'h00, 1'b0, 1'b1, 8'h5C);
    op("rd_status_cnt1", 1'b0, 1'b1, 8'h0E, 8'h00, 1'b0, 1'b1, 8'h10);
    check("rdata_held", 64'(i2c_rdata), 64'h10);

    // wr_cnt wrap
    do_reset();
    for (int i = 0; i < 16; i++)
      op("wr_r0_loop", 1'b1, 1'b0, 8'h00, 8'(i), 1'b0, 1'b0, 8'h00);
    op("rd_status_wrap", 1'b0, 1'b1, 8'h0E, 8'h00, 1'b0, 1'b1, 8'h00);
    op("wr_r0_17th", 1'b1, 1'b0, 8'h00, 8'h10, 1'b0, 1'b0, 8'h00);
    check("wr_r0_17th_pulse", 64'(pulse_at_ack), 64'h01);
    op("rd_status_cnt1b", 1'b0, 1'b1, 8'h0E, 8'h00, 1'b0, 1'b1, 8'h10);
    check("wrap_cfg", cfg_regs, 64'h0000_0000_0000_0010);

    // Error handling
    do_reset();
    op("wr_devid", 1'b1, 1'b0, 8'h0F, 8'h33, 1'b1, 1'b0, 8'h00);
    check("wr_devid_pulse", 64'(pulse_at_ack), 64'h00);
    op("rd_status_addr", 1'b0, 1'b1, 8'h0E, 8'h00, 1'b0, 1'b1, 8'h02);
    op("w1c_addr", 1'b1, 1'b0, 8'h0E, 8'h0B, 1'b0, 1'b0, 8'h00);
    op("rd_status_clr", 1'b0, 1'b1, 8'h0E, 8'h00, 1'b0, 1'b1, 8'h00);
    op("both_req", 1'b1, 1'b1, 8'h03, 8'h99, 1'b1, 1'b0, 8'h00);
    check("both_cfg", cfg_regs, 64'h0000_0000_0000_0001);
    op("rd_status_both", 1'b0, 1'b1, 8'h0E, 8'h00, 1'b0, 1'b1, 8'h08);
    op("w1c_both", 1'b1, 1'b0, 8'h0E, 8'h0B, 1'b0, 1'b0, 8'h00);

    // Second request while the first is in EXEC is dropped
    @(negedge clk);
    push("busy_wr_r1", 1'b0, 1'b0, 8'h00);
    i2c_xfc_write = 1'b1; i2c_addr = 8'h01; i2c_wdata = 8'h77;
    @(negedge clk);
    i2c_xfc_write = 1'b0; i2c_xfc_read = 1'b1; i2c_addr = 8'h05;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    check("busy_cfg", cfg_regs, 64'h0000_0000_0000_7701);
    op("rd_status_busy", 1'b0, 1'b1, 8'h0E, 8'h00, 1'b0, 1'b1, 8'h11);
    op("rd_bad_hi", 1'b0, 1'b1, 8'h20, 8'h00, 1'b1, 1'b1, 8'h00);
    op("rd_bad_mid", 1'b0, 1'b1, 8'h0A, 8'h00, 1'b1, 1'b1, 8'h00);
    op("rd_status_all", 1'b0, 1'b1, 8'h0E, 8'h00, 1'b0, 1'b1, 8'h13);

    // Reset during EXEC aborts the write and suppresses the ack
    @(negedge clk);
    i2c_xfc_write = 1'b1; i2c_addr = 8'h05; i2c_wdata = 8'hFF;
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("abort_cfg", cfg_regs, 64'h0000_0000_0000_0001);

    // Request coincident with reset is ignored
    @(negedge clk);
    reset = 1'b1;
    i2c_xfc_write = 1'b1; i2c_addr = 8'h02; i2c_wdata = 8'h33;
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_cfg", cfg_regs, 64'h0000_0000_0000_0001);
    op("rd_r5_after_abort", 1'b0, 1'b1, 8'h05, 8'h00, 1'b0, 1'b1, 8'h00);
    op("rd_status_after_rst", 1'b0, 1'b1, 8'h0E, 8'h00, 1'b0, 1'b1, 8'h00);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
